// File: rtl/pool_handoff_2.sv
// Ownership controller for layer 2's pool memories: layer 2 fills, a guard interval lets
// in-flight writes land, layer 3 drains, then layer 2 is restarted for the next frame.
module pool_handoff_2 #(
  parameter int unsigned POOL_ADDR_WIDTH = 10,
  parameter int unsigned GUARD_CYCLES    = 3,
  parameter int unsigned NUM_FRAMES      = 0,
  parameter int unsigned FRAME_CNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pool_done,
  input  logic [POOL_ADDR_WIDTH-1:0] prod_address_a,
  input  logic [POOL_ADDR_WIDTH-1:0] prod_address_b,
  input  logic                       prod_rden_a,
  input  logic                       prod_rden_b,
  input  logic                       prod_wren_a,
  input  logic                       prod_wren_b,
  input  logic [POOL_ADDR_WIDTH-1:0] cons_address_a,
  input  logic [POOL_ADDR_WIDTH-1:0] cons_address_b,
  input  logic                       cons_rden_a,
  input  logic                       cons_rden_b,
  input  logic                       cons_done,
  output logic [POOL_ADDR_WIDTH-1:0] mem_address_a,
  output logic [POOL_ADDR_WIDTH-1:0] mem_address_b,
  output logic                       mem_rden_a,
  output logic                       mem_rden_b,
  output logic                       mem_wren_a,
  output logic                       mem_wren_b,
  output logic                       prod_enable,
  output logic                       prod_restart,
  output logic                       cons_enable,
  output logic                       busy,
  output logic                       all_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  typedef enum logic [2:0] {StIdle, StFill, StGuard, StDrain, StRelease} state_e;

  localparam logic [3:0]                 GuardLoad  = 4'(GUARD_CYCLES - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FrameLimit = FRAME_CNT_WIDTH'(NUM_FRAMES);
  localparam bit                         Bounded    = (NUM_FRAMES != 0);

  state_e                     state_q, state_d;
  logic                       pool_done_q, cons_done_q;
  logic [3:0]                 guard_q, guard_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_q, frame_d, frame_inc;
  logic                       all_done_q, all_done_d;
  logic                       pool_edge, cons_edge;

  assign pool_edge = pool_done & ~pool_done_q;
  assign cons_edge = cons_done & ~cons_done_q;
  assign frame_inc = frame_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    frame_d    = frame_q;
    all_done_d = all_done_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFill;
          frame_d    = '0;
          all_done_d = 1'b0;
        end
      end
      StFill: begin
        if (pool_edge) begin
          state_d = StGuard;
          guard_d = GuardLoad;
        end
      end
      StGuard: begin
        if (guard_q == 4'd0) state_d = StDrain;
        else                 guard_d = guard_q - 4'd1;
      end
      StDrain: begin
        if (cons_edge) state_d = StRelease;
      end
      StRelease: begin
        frame_d = frame_inc;
        if (Bounded && (frame_inc == FrameLimit)) begin
          state_d    = StIdle;
          all_done_d = 1'b1;
        end else begin
          state_d = StFill;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      pool_done_q <= 1'b0;
      cons_done_q <= 1'b0;
      guard_q     <= 4'd0;
      frame_q     <= '0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pool_done_q <= pool_done;
      cons_done_q <= cons_done;
      guard_q     <= guard_d;
      frame_q     <= frame_d;
      all_done_q  <= all_done_d;
    end
  end

  // Producer keeps the port through GUARD so its last writes still land.
  always_comb begin
    mem_address_a = '0;
    mem_address_b = '0;
    mem_rden_a    = 1'b0;
    mem_rden_b    = 1'b0;
    mem_wren_a    = 1'b0;
    mem_wren_b    = 1'b0;
    case (state_q)
      StFill, StGuard: begin
        mem_address_a = prod_address_a;
        mem_address_b = prod_address_b;
        mem_rden_a    = prod_rden_a;
        mem_rden_b    = prod_rden_b;
        mem_wren_a    = prod_wren_a;
        mem_wren_b    = prod_wren_b;
      end
      StDrain: begin
        mem_address_a = cons_address_a;
        mem_address_b = cons_address_b;
        mem_rden_a    = cons_rden_a;
        mem_rden_b    = cons_rden_b;
      end
      default: ;
    endcase
  end

  assign prod_enable  = (state_q == StFill);
  assign cons_enable  = (state_q == StDrain);
  assign prod_restart = (state_q == StRelease);
  assign busy         = (state_q != StIdle);
  assign all_done     = all_done_q;
  assign frame_count  = frame_q;

endmodule

// File: tb/tb_pool_handoff_2.sv
// Bench for pool_handoff_2: instance a is bounded to one frame, instance b is unbounded with a
// 2-bit frame counter; both share the same stimulus.
module tb_pool_handoff_2;

  localparam int unsigned AW = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start, pool_done, cons_done;
  logic [AW-1:0] prod_address_a, prod_address_b, cons_address_a, cons_address_b;
  logic          prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b, cons_rden_a, cons_rden_b;

  logic [AW-1:0] a_mem_address_a, a_mem_address_b;
  logic          a_mem_rden_a, a_mem_rden_b, a_mem_wren_a, a_mem_wren_b;
  logic          a_prod_enable, a_prod_restart, a_cons_enable, a_busy, a_all_done;
  logic [7:0]    a_frame_count;

  logic [AW-1:0] b_mem_address_a, b_mem_address_b;
  logic          b_mem_rden_a, b_mem_rden_b, b_mem_wren_a, b_mem_wren_b;
  logic          b_prod_enable, b_prod_restart, b_cons_enable, b_busy, b_all_done;
  logic [1:0]    b_frame_count;

  pool_handoff_2 #(
    .POOL_ADDR_WIDTH(AW), .GUARD_CYCLES(3), .NUM_FRAMES(1), .FRAME_CNT_WIDTH(8)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start), .pool_done(pool_done),
    .prod_address_a(prod_address_a), .prod_address_b(prod_address_b),
    .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
    .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
    .cons_address_a(cons_address_a), .cons_address_b(cons_address_b),
    .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b), .cons_done(cons_done),
    .mem_address_a(a_mem_address_a), .mem_address_b(a_mem_address_b),
    .mem_rden_a(a_mem_rden_a), .mem_rden_b(a_mem_rden_b),
    .mem_wren_a(a_mem_wren_a), .mem_wren_b(a_mem_wren_b),
    .prod_enable(a_prod_enable), .prod_restart(a_prod_restart), .cons_enable(a_cons_enable),
    .busy(a_busy), .all_done(a_all_done), .frame_count(a_frame_count)
  );

  pool_handoff_2 #(
    .POOL_ADDR_WIDTH(AW), .GUARD_CYCLES(3), .NUM_FRAMES(0), .FRAME_CNT_WIDTH(2)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start), .pool_done(pool_done),
    .prod_address_a(prod_address_a), .prod_address_b(prod_address_b),
    .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
    .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
    .cons_address_a(cons_address_a), .cons_address_b(cons_address_b),
    .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b), .cons_done(cons_done),
    .mem_address_a(b_mem_address_a), .mem_address_b(b_mem_address_b),
    .mem_rden_a(b_mem_rden_a), .mem_rden_b(b_mem_rden_b),
    .mem_wren_a(b_mem_wren_a), .mem_wren_b(b_mem_wren_b),
    .prod_enable(b_prod_enable), .prod_restart(b_prod_restart), .cons_enable(b_cons_enable),
    .busy(b_busy), .all_done(b_all_done), .frame_count(b_frame_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    start = 0; pool_done = 0; cons_done = 0;
    prod_address_a = '0; prod_address_b = '0; cons_address_a = '0; cons_address_b = '0;
    prod_rden_a = 0; prod_rden_b = 0; prod_wren_a = 0; prod_wren_b = 0;
    cons_rden_a = 0; cons_rden_b = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    repeat (3) tick();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [36:0] a_all;
    logic [30:0] b_all;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      {start, pool_done, cons_done, prod_wren_a, prod_wren_b, prod_rden_a, prod_rden_b,
       cons_rden_a, cons_rden_b} = 9'($urandom);
      prod_address_a = AW'($urandom); cons_address_b = AW'($urandom);
      tick();
      a_all = {a_mem_address_a, a_mem_address_b, a_mem_rden_a, a_mem_rden_b, a_mem_wren_a,
               a_mem_wren_b, a_prod_enable, a_prod_restart, a_cons_enable, a_busy, a_all_done,
               a_frame_count};
      b_all = {b_mem_address_a, b_mem_address_b, b_mem_rden_a, b_mem_rden_b, b_mem_wren_a,
               b_mem_wren_b, b_prod_enable, b_prod_restart, b_cons_enable, b_busy, b_all_done,
               b_frame_count};
      n_checks++;
      if (a_all !== '0) begin
        n_fail++; $display("FAIL reset_outputs_a: got %h, want 0", a_all);
      end
      n_checks++;
      if (b_all !== '0) begin
        n_fail++; $display("FAIL reset_outputs_b: got %h, want 0", b_all);
      end
    end
    clear_inputs();
    reset = 0;
  endtask

  task automatic test_single_frame();
    logic [7:0] exp;
    do_reset();
    start = 1; tick(); start = 0;
    n_checks++;
    if ({a_prod_enable, a_busy, a_cons_enable} !== 3'b110) begin
      n_fail++; $display("FAIL fill_entry: got %b, want 110", {a_prod_enable, a_busy, a_cons_enable});
    end
    for (int i = 0; i < 33; i++) begin
      tick();
      n_checks++;
      if (a_prod_enable !== 1'b1) begin
        n_fail++; $display("FAIL fill_hold cyc %0d: prod_enable %b, want 1", i, a_prod_enable);
      end
    end
    pool_done = 1; tick();
    n_checks++;
    if ({a_prod_enable, a_cons_enable, a_busy} !== 3'b001) begin
      n_fail++; $display("FAIL guard_entry: got %b, want 001", {a_prod_enable, a_cons_enable, a_busy});
    end
    tick(); tick();
    n_checks++;
    if (a_cons_enable !== 1'b0) begin
      n_fail++; $display("FAIL guard_len: cons_enable %b early, want 0", a_cons_enable);
    end
    tick(); pool_done = 0;
    n_checks++;
    if (a_cons_enable !== 1'b1) begin
      n_fail++; $display("FAIL drain_entry: cons_enable %b, want 1", a_cons_enable);
    end
    repeat (10) tick();
    cons_done = 1; exp_q.push_back(8'd1); tick(); cons_done = 0;
    n_checks++;
    if ({a_prod_restart, a_cons_enable, a_busy, a_frame_count} !== {3'b101, 8'd0}) begin
      n_fail++; $display("FAIL release: got %b/%0d, want 101/0",
                         {a_prod_restart, a_cons_enable, a_busy}, a_frame_count);
    end
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if ({a_frame_count, a_all_done, a_busy, a_prod_restart} !== {exp, 3'b100}) begin
      n_fail++; $display("FAIL frame_done: count %0d done %b busy %b restart %b, want %0d 1 0 0",
                         a_frame_count, a_all_done, a_busy, a_prod_restart, exp);
    end
    tick();
    n_checks++;
    if ({a_all_done, a_busy} !== 2'b10) begin
      n_fail++; $display("FAIL all_done_sticky: got %b, want 10", {a_all_done, a_busy});
    end
  endtask

  task automatic test_mux();
    do_reset();
    start = 1; tick(); start = 0;
    prod_address_a = 10'h155; prod_wren_a = 1; prod_address_b = 10'h033; cons_address_b = 10'h2AA;
    #1;
    n_checks++;
    if ({a_mem_address_a, a_mem_wren_a, a_mem_address_b} !== {10'h155, 1'b1, 10'h033}) begin
      n_fail++; $display("FAIL mux_fill: got %h %b %h, want 155 1 033",
                         a_mem_address_a, a_mem_wren_a, a_mem_address_b);
    end
    pool_done = 1; tick(); pool_done = 0; #1;
    n_checks++;
    if ({a_mem_address_a, a_mem_wren_a} !== {10'h155, 1'b1}) begin
      n_fail++; $display("FAIL mux_guard: got %h %b, want 155 1", a_mem_address_a, a_mem_wren_a);
    end
    tick(); tick(); tick();
    cons_rden_b = 1; #1;
    n_checks++;
    if ({a_cons_enable, a_mem_address_b, a_mem_rden_b, a_mem_wren_a, a_mem_wren_b}
        !== {1'b1, 10'h2AA, 3'b100}) begin
      n_fail++; $display("FAIL mux_drain: en %b addr %h rden %b wren %b%b, want 1 2aa 1 00",
                         a_cons_enable, a_mem_address_b, a_mem_rden_b, a_mem_wren_a, a_mem_wren_b);
    end
    // Spurious pool_done and start while draining must not move the state.
    pool_done = 1; tick(); pool_done = 0; start = 1; tick(); start = 0; tick();
    n_checks++;
    if ({a_cons_enable, a_prod_enable, a_prod_restart} !== 3'b100) begin
      n_fail++; $display("FAIL spurious_drain: got %b, want 100",
                         {a_cons_enable, a_prod_enable, a_prod_restart});
    end
  endtask

  task automatic test_spurious_fill();
    do_reset();
    start = 1; tick(); start = 0;
    cons_done = 1; tick(); cons_done = 0; tick(); tick();
    n_checks++;
    if ({a_prod_enable, a_cons_enable, a_prod_restart, a_frame_count} !== {3'b100, 8'd0}) begin
      n_fail++; $display("FAIL spurious_fill: got %b/%0d, want 100/0",
                         {a_prod_enable, a_cons_enable, a_prod_restart}, a_frame_count);
    end
  endtask

  task automatic run_frame_b(input logic [1:0] exp_cnt);
    logic [7:0] exp;
    int         t;
    pool_done = 1; tick(); pool_done = 0;
    t = 0;
    while (b_cons_enable !== 1'b1 && t < 10) begin tick(); t++; end
    n_checks++;
    if (t != 3) begin
      n_fail++; $display("FAIL loop_guard: drain after %0d cycles, want 3", t);
    end
    repeat (2) tick();
    cons_done = 1; exp_q.push_back({6'd0, exp_cnt}); tick(); cons_done = 0;
    n_checks++;
    if (b_prod_restart !== 1'b1) begin
      n_fail++; $display("FAIL loop_restart: prod_restart %b, want 1", b_prod_restart);
    end
    tick();
    exp = exp_q.pop_front();
    n_checks++;
    if ({6'd0, b_frame_count} !== exp || b_all_done !== 1'b0 || b_prod_enable !== 1'b1) begin
      n_fail++; $display("FAIL loop_frame: count %0d done %b pe %b, want %0d 0 1",
                         b_frame_count, b_all_done, b_prod_enable, exp);
    end
  endtask

  task automatic test_unbounded();
    logic [1:0] m;
    do_reset();
    start = 1; tick(); start = 0;
    m = 2'd0;
    for (int f = 0; f < 5; f++) begin
      m = 2'((int'(m) + 1) % 4);
      run_frame_b(m);
    end
  endtask

  task automatic test_reset_mid_drain();
    // b is still in FILL with a non-zero count from the previous test.
    pool_done = 1; tick(); pool_done = 0;
    repeat (3) tick();
    n_checks++;
    if (b_cons_enable !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_drain: cons_enable %b, want 1", b_cons_enable);
    end
    reset = 1; cons_done = 1; start = 1; tick();
    n_checks++;
    if ({b_cons_enable, b_busy, b_prod_restart, b_frame_count} !== 5'b0) begin
      n_fail++; $display("FAIL reset_mid_drain: en %b busy %b rst %b count %0d, want 0 0 0 0",
                         b_cons_enable, b_busy, b_prod_restart, b_frame_count);
    end
    reset = 0; cons_done = 0; start = 0; tick();
    n_checks++;
    if ({b_prod_restart, b_busy} !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_idle: got %b, want 00", {b_prod_restart, b_busy});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_single_frame();
    test_mux();
    test_spurious_fill();
    test_unbounded();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
